int_to_recoded_float_seq: RTL and testbench

INT_TO_RECODED_FLOAT_SEQ -- requirements
Module: int_to_recoded_float_seq

---
 rtl/int_to_recoded_float_seq.sv | 195 +++++++++++++++++++
 tb/tb_int_to_recoded_float_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/int_to_recoded_float_seq.sv
// -----------------------------------------------------------------------------
// int_to_recoded_float_seq
//
// Converts a signed or unsigned integer to a recoded floating-point value
// {sign, exp[expSize:0], sig[sigSize-2:0]}. The conversion is sequential:
// the magnitude is normalised one bit per cycle and then rounded in a
// single cycle. Only one operation is in flight at a time.
//
// Parameters
//   expSize : exponent width of the standard format (recoded exp is +1 bit)
//   sigSize : significand width including the hidden bit
//   intSize : integer operand width (intSize > sigSize and
//             intSize-1 < 2^(expSize-1))
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   in_valid    : operand fields valid
//   in_ready    : block idle, can accept an operand
//   in_int      : integer operand
//   in_signed   : 1 = two's-complement operand, 0 = unsigned
//   in_rm       : rounding mode (00 RNE, 01 RTZ, 10 RDN, 11 RUP)
//   out_valid   : result valid (held until out_ready)
//   out_ready   : consumer accepts the result
//   out_float   : recoded float result
//   out_inexact : result differs from the operand
// -----------------------------------------------------------------------------
module int_to_recoded_float_seq #(
  parameter int expSize = 8,
  parameter int sigSize = 24,
  parameter int intSize = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [intSize-1:0]         in_int,
  input  logic                       in_signed,
  input  logic [1:0]                 in_rm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [expSize+sigSize:0]   out_float,
  output logic                       out_inexact
);

  localparam int CntW = $clog2(intSize);
  localparam int FracW = sigSize - 1;

  // Recoded exponent of 1.0 * 2^count is 2^expSize + count.
  localparam logic [expSize:0] ExpBias = {1'b1, {expSize{1'b0}}};
  localparam logic [CntW-1:0]  CntInit = CntW'(intSize - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q;
  logic [intSize-1:0]        mag_q;
  logic [CntW-1:0]           count_q;
  logic                      sign_q;
  logic [1:0]                rm_q;
  logic [expSize+sigSize:0]  out_float_q;
  logic                      out_inexact_q;

  logic                      in_sign_s;
  logic [intSize-1:0]        in_mag_s;
  logic [FracW-1:0]          sig_s;
  logic                      guard_s;
  logic                      sticky_s;
  logic                      inc_s;
  logic [expSize:0]          exp_base_s;
  logic [FracW-1:0]          sig_d;
  logic [expSize:0]          exp_d;

  // Rounding increment decision for the four supported modes.
  function automatic logic round_inc(
    input logic [1:0] rm,
    input logic       sign,
    input logic       guard,
    input logic       sticky,
    input logic       lsb
  );
    logic inc;
    case (rm)
      2'b00:   inc = guard & (sticky | lsb);
      2'b01:   inc = 1'b0;
      2'b10:   inc = sign & (guard | sticky);
      2'b11:   inc = ~sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Handshake flags are pure decodes of the FSM state.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_float   = out_float_q;
  assign out_inexact = out_inexact_q;

  // Operand sign and magnitude; the most negative value negates to
  // 2^(intSize-1), which is still correct as an unsigned magnitude.
  always_comb begin
    in_sign_s = in_signed & in_int[intSize-1];
    if (in_sign_s) begin
      in_mag_s = (~in_int) + {{(intSize-1){1'b0}}, 1'b1};
    end else begin
      in_mag_s = in_int;
    end
  end

  // Sticky covers every bit below the guard; there may be none.
  if (intSize - sigSize >= 2) begin : g_sticky
    assign sticky_s = |mag_q[intSize-sigSize-2:0];
  end else begin : g_no_sticky
    assign sticky_s = 1'b0;
  end

  // Rounding datapath on the normalised magnitude (MSB is the hidden bit).
  always_comb begin
    sig_s      = mag_q[intSize-2 -: FracW];
    guard_s    = mag_q[intSize-sigSize-1];
    inc_s      = round_inc(rm_q, sign_q, guard_s, sticky_s, sig_s[0]);
    exp_base_s = ExpBias + {{(expSize+1-CntW){1'b0}}, count_q};
    if (inc_s && (&sig_s)) begin
      // Carry out of the fraction: mantissa wraps to 1.0, exponent bumps.
      sig_d = {FracW{1'b0}};
      exp_d = exp_base_s + {{expSize{1'b0}}, 1'b1};
    end else begin
      sig_d = sig_s + {{(FracW-1){1'b0}}, inc_s};
      exp_d = exp_base_s;
    end
  end

  // Control FSM with operand capture, normalisation and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mag_q         <= {intSize{1'b0}};
      count_q       <= {CntW{1'b0}};
      sign_q        <= 1'b0;
      rm_q          <= 2'b00;
      out_float_q   <= {(expSize+sigSize+1){1'b0}};
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign_s;
            mag_q   <= in_mag_s;
            rm_q    <= in_rm;
            count_q <= CntInit;
            if (in_mag_s == {intSize{1'b0}}) begin
              // Zero converts exactly to +0 and skips normalisation.
              out_float_q   <= {(expSize+sigSize+1){1'b0}};
              out_inexact_q <= 1'b0;
              state_q       <= DONE;
            end else begin
              state_q <= NORM;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        NORM: begin
          if (mag_q[intSize-1]) begin
            state_q <= ROUND;
          end else begin
            mag_q   <= {mag_q[intSize-2:0], 1'b0};
            count_q <= count_q - {{(CntW-1){1'b0}}, 1'b1};
            state_q <= NORM;
          end
        end
        ROUND: begin
          out_float_q   <= {sign_q, exp_d, sig_d};
          out_inexact_q <= guard_s | sticky_s;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_recoded_float_seq.sv
module tb_int_to_recoded_float_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        in_signed;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_float;
  logic        out_inexact;

  int n_chk;
  int n_bad;

  int_to_recoded_float_seq #(
    .expSize(8),
    .sigSize(24),
    .intSize(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_int     (in_int),
    .in_signed  (in_signed),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_float  (out_float),
    .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        s;
    logic [1:0]  rm;
    logic [32:0] f;
    logic        x;
    int          lat;   // edges after the accepting edge until out_valid
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand, let it be accepted, then scramble the inputs.
  task automatic start_op(input logic [31:0] v, input logic s, input logic [1:0] rm);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_int    = v;
    in_signed = s;
    in_rm     = rm;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_int    = ~v;
    in_signed = ~s;
    in_rm     = ~rm;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t t);
    int lat;
    start_op(t.v, t.s, t.rm);
    wait_done(lat);
    chk("latency", 64'(lat), 64'(t.lat));
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("out_float", {31'd0, out_float}, {31'd0, t.f});
    chk("out_inexact", {63'd0, out_inexact}, {63'd0, t.x});
    chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
    handshake();
  endtask

  initial begin
    int   lat;
    logic saw_valid;
    n_chk = 0;
    n_bad = 0;

    vecs[0]  = '{32'h00000001, 1'b1, 2'b00, 33'h080000000, 1'b0, 33};
    vecs[1]  = '{32'hFFFFFFFF, 1'b1, 2'b00, 33'h180000000, 1'b0, 33};
    vecs[2]  = '{32'h80000000, 1'b1, 2'b00, 33'h18F800000, 1'b0, 2};
    vecs[3]  = '{32'hFFFFFFFF, 1'b0, 2'b00, 33'h090000000, 1'b1, 2};
    vecs[4]  = '{32'hFFFFFFFF, 1'b0, 2'b01, 33'h08FFFFFFF, 1'b1, 2};
    vecs[5]  = '{32'h00000000, 1'b1, 2'b00, 33'h000000000, 1'b0, 0};
    vecs[6]  = '{32'hFFFFFFFF, 1'b0, 2'b10, 33'h08FFFFFFF, 1'b1, 2};
    vecs[7]  = '{32'hFFFFFFFF, 1'b0, 2'b11, 33'h090000000, 1'b1, 2};
    vecs[8]  = '{32'hFFFFFFFD, 1'b1, 2'b00, 33'h180C00000, 1'b0, 32};
    vecs[9]  = '{32'h01000001, 1'b0, 2'b00, 33'h08C000000, 1'b1, 9};
    vecs[10] = '{32'h01000001, 1'b0, 2'b11, 33'h08C000001, 1'b1, 9};
    vecs[11] = '{32'hFEFFFFFF, 1'b1, 2'b10, 33'h18C000001, 1'b1, 9};
    vecs[12] = '{32'hFEFFFFFF, 1'b1, 2'b01, 33'h18C000000, 1'b1, 9};
    vecs[13] = '{32'h01000003, 1'b0, 2'b00, 33'h08C000002, 1'b1, 9};
    vecs[14] = '{32'h00FFFFFF, 1'b0, 2'b00, 33'h08BFFFFFF, 1'b0, 10};
    vecs[15] = '{32'h80000000, 1'b0, 2'b00, 33'h08F800000, 1'b0, 2};
    vecs[16] = '{32'h7FFFFFFF, 1'b1, 2'b00, 33'h08F800000, 1'b1, 3};
    vecs[17] = '{32'h00000000, 1'b0, 2'b11, 33'h000000000, 1'b0, 0};

    // Reset with in_valid asserted: nothing may be accepted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_int    = 32'h00000005;
    in_signed = 1'b0;
    in_rm     = 2'b00;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_float", {31'd0, out_float}, 64'd0);
    chk("rst_out_inexact", {63'd0, out_inexact}, 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure in DONE with a competing operand offered throughout.
    start_op(32'h00000005, 1'b0, 2'b00);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd31);
    in_int   = 32'h12345678;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_float", {31'd0, out_float}, {31'd0, 33'h081200000});
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    handshake();
    tick();
    chk("bp_nothing_accepted", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of normalisation discards the operation.
    start_op(32'h00000001, 1'b0, 2'b00);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_float", {31'd0, out_float}, 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("midrst_no_pulse", {63'd0, saw_valid}, 64'd0);
    run_vec(vecs[8]);
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
